// File: rtl/calc_pkg.sv
// Shared encodings for the calculator control stage.
// State, operator and key-class codes used by RTL and bench alike.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTER_B = 3'd2,
    RESULT  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  typedef enum logic [1:0] {
    KEY_NONE = 2'd0,
    KEY_NUM  = 2'd1,
    KEY_OP   = 2'd2,
    KEY_EQ   = 2'd3
  } key_class_t;

endpackage

// File: rtl/calc_ctrl_if.sv
// Keypad-to-control and control-to-display signal bundle.
// master = keypad/display side, slave = calc_ctrl.
interface calc_ctrl_if #(
  parameter int WIDTH = 12
);
  logic             any_btn;
  logic             is_number;
  logic             is_op;
  logic             is_eq;
  logic [3:0]       num_val;
  logic [1:0]       op_val;
  logic [WIDTH-1:0] disp_val;
  logic             err;
  logic             key_evt;
  logic [2:0]       state;

  modport master (
    output any_btn, is_number, is_op, is_eq,
    output num_val, op_val,
    input  disp_val, err, key_evt, state
  );

  modport slave (
    input  any_btn, is_number, is_op, is_eq,
    input  num_val, op_val,
    output disp_val, err, key_evt, state
  );
endinterface

// File: rtl/calc_ctrl_key_event.sv
// Debounces keypad activity into one validated event per press.
// One counter serves both the press and the release debounce.
module key_event
  import calc_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_any_btn,
  input  logic       i_is_number,
  input  logic       i_is_op,
  input  logic       i_is_eq,
  input  logic [3:0] i_num_val,
  input  logic [1:0] i_op_val,
  output logic       o_evt,
  output key_class_t o_evt_class,
  output logic [3:0] o_evt_val
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] r_cnt;
  logic          r_latched;
  logic          r_evt;
  key_class_t    r_class;
  logic [3:0]    r_val;

  key_class_t    w_class;
  logic [3:0]    w_val;

  // eq > op > number; malformed keys become KEY_NONE
  always_comb begin
    w_class = KEY_NONE;
    w_val   = 4'd0;
    priority case (1'b1)
      i_is_eq: w_class = KEY_EQ;
      i_is_op: begin
        if (i_op_val == OP_ADD || i_op_val == OP_SUB) begin
          w_class = KEY_OP;
          w_val   = {2'b00, i_op_val};
        end
      end
      i_is_number: begin
        if (i_num_val <= 4'd9) begin
          w_class = KEY_NUM;
          w_val   = i_num_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_latched <= 1'b0;
      r_evt     <= 1'b0;
      r_class   <= KEY_NONE;
      r_val     <= 4'd0;
    end else begin
      r_evt <= 1'b0;
      if (!r_latched) begin
        if (!i_any_btn) begin
          r_cnt <= '0;
        end else if (r_cnt == LAST) begin
          r_cnt     <= '0;
          r_latched <= 1'b1;
          r_evt     <= 1'b1;
          r_class   <= w_class;
          r_val     <= w_val;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        if (i_any_btn) begin
          r_cnt <= '0;
        end else if (r_cnt == LAST) begin
          r_cnt     <= '0;
          r_latched <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_evt       = r_evt;
  assign o_evt_class = r_class;
  assign o_evt_val   = r_val;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator control: operand entry, add/sub chaining, overflow error.
// All display outputs are registered and update the edge after key_evt.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int WIDTH    = 12,
  parameter int DEBOUNCE = 4
) (
  input logic        clk,
  input logic        reset,
  calc_ctrl_if.slave bus
);

  localparam int MAX_VAL = 10 ** DIGITS - 1;
  localparam int NW = $clog2(DIGITS + 1);
  localparam logic signed [WIDTH-1:0] MAXV =
    WIDTH'(MAX_VAL);

  logic                    w_evt;
  key_class_t              w_cls;
  logic [3:0]              w_val;
  logic signed [WIDTH-1:0] w_d;
  logic signed [WIDTH-1:0] w_app_a;
  logic signed [WIDTH-1:0] w_app_b;
  logic signed [WIDTH-1:0] w_res;
  logic                    w_ovf;
  logic                    w_room;
  logic [1:0]              w_op;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_a;
  logic signed [WIDTH-1:0] r_b;
  logic [1:0]              r_op;
  logic [NW-1:0]           r_ndig;
  logic signed [WIDTH-1:0] r_disp;
  logic                    r_err;

  key_event #(
    .DEBOUNCE (DEBOUNCE)
  ) u_key (
    .clk         (clk),
    .reset       (reset),
    .i_any_btn   (bus.any_btn),
    .i_is_number (bus.is_number),
    .i_is_op     (bus.is_op),
    .i_is_eq     (bus.is_eq),
    .i_num_val   (bus.num_val),
    .i_op_val    (bus.op_val),
    .o_evt       (w_evt),
    .o_evt_class (w_cls),
    .o_evt_val   (w_val)
  );

  assign w_d     = WIDTH'(w_val);
  assign w_op    = w_val[1:0];
  assign w_app_a = (r_a <<< 3) + (r_a <<< 1) + w_d;
  assign w_app_b = (r_b <<< 3) + (r_b <<< 1) + w_d;
  assign w_res   = (r_op == OP_SUB) ? r_a - r_b
                                    : r_a + r_b;
  assign w_ovf   = (w_res > MAXV) || (w_res < -MAXV);
  assign w_room  = r_ndig < NW'(DIGITS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_ndig  <= '0;
      r_disp  <= '0;
      r_err   <= 1'b0;
    end else if (w_evt) begin
      case (r_state)
        ENTER_A: begin
          if (w_cls == KEY_NUM && w_room) begin
            r_a    <= w_app_a;
            r_disp <= w_app_a;
            r_ndig <= r_ndig + NW'(1);
          end else if (w_cls == KEY_OP) begin
            r_op    <= w_op;
            r_state <= OP_WAIT;
          end
        end
        OP_WAIT: begin
          if (w_cls == KEY_NUM) begin
            r_b     <= w_d;
            r_disp  <= w_d;
            r_ndig  <= NW'(1);
            r_state <= ENTER_B;
          end else if (w_cls == KEY_OP) begin
            r_op <= w_op;
          end
        end
        ENTER_B: begin
          if (w_cls == KEY_NUM) begin
            if (w_room) begin
              r_b    <= w_app_b;
              r_disp <= w_app_b;
              r_ndig <= r_ndig + NW'(1);
            end
          end else if (w_cls == KEY_OP ||
                       w_cls == KEY_EQ) begin
            // overflow leaves A untouched and parks in ERROR
            if (w_ovf) begin
              r_state <= ERROR;
              r_err   <= 1'b1;
              r_disp  <= '0;
            end else begin
              r_a    <= w_res;
              r_disp <= w_res;
              if (w_cls == KEY_OP) begin
                r_op    <= w_op;
                r_state <= OP_WAIT;
              end else begin
                r_state <= RESULT;
              end
            end
          end
        end
        RESULT: begin
          if (w_cls == KEY_NUM) begin
            r_a     <= w_d;
            r_disp  <= w_d;
            r_ndig  <= NW'(1);
            r_state <= ENTER_A;
          end else if (w_cls == KEY_OP) begin
            r_op    <= w_op;
            r_state <= OP_WAIT;
          end
        end
        ERROR: begin
          if (w_cls == KEY_EQ) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ndig  <= '0;
            r_err   <= 1'b0;
            r_disp  <= '0;
            r_state <= ENTER_A;
          end
        end
        default: r_state <= ENTER_A;
      endcase
    end
  end

  assign bus.disp_val = r_disp;
  assign bus.err      = r_err;
  assign bus.key_evt  = w_evt;
  assign bus.state    = r_state;

endmodule
